// File: rtl/spi_frame_decoder.sv
// SPI command front-end: deserializes {rw, addr[6:0]} [+ data byte] frames on sclk.
// Optional burst auto-increment of addr_out is enabled by defining SPI_AUTO_INCR_EN.
module spi_frame_decoder #(
  parameter int NUM_REGS = 59,
  parameter int ADDR_W   = 8
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              mosi,
  output logic [ADDR_W-1:0] addr_out,
  output logic              rd_load,
  output logic              wr_en,
  output logic [7:0]        wr_data,
  output logic              err,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, CMD, DATA, RD, DONE} state_t;

  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(NUM_REGS);

  state_t            state_reg, state_next;
  logic [4:0]        bit_cnt_reg, bit_cnt_next;
  logic [6:0]        shift_reg, shift_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              rd_load_reg, rd_load_next;
  logic              wr_en_reg, wr_en_next;
  logic [7:0]        wr_data_reg, wr_data_next;
  logic              err_reg, err_next;
  logic              busy_reg;

  logic [7:0]        cmd;
  logic [ADDR_W-1:0] cmd_addr;
  logic [4:0]        bit_cnt_sat;
`ifdef SPI_AUTO_INCR_EN
  logic [ADDR_W-1:0] addr_inc;
`endif

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      addr_reg    <= '0;
      rd_load_reg <= 1'b0;
      wr_en_reg   <= 1'b0;
      wr_data_reg <= '0;
      err_reg     <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      addr_reg    <= addr_next;
      rd_load_reg <= rd_load_next;
      wr_en_reg   <= wr_en_next;
      wr_data_reg <= wr_data_next;
      err_reg     <= err_next;
      busy_reg    <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    addr_next    = addr_reg;
    rd_load_next = 1'b0;
    wr_en_next   = 1'b0;
    wr_data_next = wr_data_reg;
    err_next     = err_reg;
    cmd          = {shift_reg, mosi};
    cmd_addr     = {{(ADDR_W-7){1'b0}}, cmd[6:0]};
    bit_cnt_sat  = (bit_cnt_reg == 5'd31) ? bit_cnt_reg : bit_cnt_reg + 5'd1;
`ifdef SPI_AUTO_INCR_EN
    addr_inc     = addr_reg + 1'b1;
`endif

    if (state_reg == IDLE) begin
      if (!cs_n) begin
        err_next     = 1'b0;
        shift_next   = {6'b0, mosi};
        bit_cnt_next = 5'd1;
        state_next   = CMD;
      end
    end else if (cs_n) begin
      // bit_cnt sits at 16 in DATA only on a byte boundary inside a write burst
      state_next   = IDLE;
      bit_cnt_next = '0;
      if (state_reg == CMD || (state_reg == DATA && bit_cnt_reg != 5'd16))
        err_next = 1'b1;
    end else begin
      bit_cnt_next = bit_cnt_sat;
      shift_next   = {shift_reg[5:0], mosi};
      case (state_reg)
        CMD: begin
          if (bit_cnt_reg == 5'd7) begin
            addr_next = cmd_addr;
            if (cmd[6:0] == 7'd0 || cmd_addr > MAX_ADDR) begin
              err_next   = 1'b1;
              state_next = DONE;
            end else if (cmd[7]) begin
              rd_load_next = 1'b1;
              state_next   = RD;
            end else begin
              state_next = DATA;
            end
          end
        end
        DATA: begin
`ifdef SPI_AUTO_INCR_EN
          // Advance the address the cycle after the strobe so wr_en sees the old one
          if (wr_en_reg) begin
            if (addr_inc > MAX_ADDR) begin
              err_next   = 1'b1;
              state_next = DONE;
            end else begin
              addr_next = addr_inc;
            end
          end
`endif
          if (bit_cnt_reg[2:0] == 3'b111) begin
            wr_en_next   = 1'b1;
            wr_data_next = cmd;
`ifdef SPI_AUTO_INCR_EN
            bit_cnt_next = 5'd16;
`else
            state_next   = DONE;
`endif
          end
        end
        RD: begin
`ifdef SPI_AUTO_INCR_EN
          if (bit_cnt_reg == 5'd15) begin
            bit_cnt_next = 5'd8;
            if (addr_inc > MAX_ADDR) begin
              err_next   = 1'b1;
              state_next = DONE;
            end else begin
              addr_next    = addr_inc;
              rd_load_next = 1'b1;
            end
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign addr_out = addr_reg;
  assign rd_load  = rd_load_reg;
  assign wr_en    = wr_en_reg;
  assign wr_data  = wr_data_reg;
  assign err      = err_reg;
  assign busy     = busy_reg;

endmodule
